bp_be_issue_queue: RTL and testbench

- Parametrised successor to the backend's single-entry FE queue handshake (clr/deq/roll).
- Buffers FE queue packets between front end and scheduler.
- Keeps three pointers: write, speculative issue, committed.
- Supports multi-entry commit per cycle, rollback of issued-but-uncommitted entries, and flush.
- Sits between the FE queue output and the backend scheduler.

---
 rtl/bp_be_pkg.sv | 25 ++
 rtl/bp_be_issue_queue_ptr.sv | 44 ++++
 rtl/bp_be_issue_queue.sv | 162 ++++++++++++++++
 tb/tb_bp_be_issue_queue.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// ---------------------------------------------------------------------------
// bp_be_pkg
//   Definitions shared by the backend issue-queue files.
//   - fe_queue_width_gp / bp_fe_queue_s : FE queue packet width and type.
//   - ptr_dist()                       : wrap-aware distance between two
//                                        wrap-bit pointers, masked to the
//                                        pointer width.
// ---------------------------------------------------------------------------
package bp_be_pkg;

    localparam int fe_queue_width_gp = 64;

    typedef logic [fe_queue_width_gp-1:0] bp_fe_queue_s;

    // Pointers carry a wrap bit as MSB, so (a - b) modulo 2^ptr_w is the
    // number of entries from b up to a, even after either pointer rolls over.
    function automatic logic [31:0] ptr_dist(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int          ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/bp_be_issue_queue_ptr.sv
// ---------------------------------------------------------------------------
// bp_be_issue_queue_ptr
//   One wrap-bit pointer register. Each cycle it either loads a new value or
//   advances by a variable amount; the pointer wraps naturally modulo
//   2^ptr_width_p.
//
// Ports:
//   clk_i     in   clock
//   reset_i   in   synchronous active-high reset, clears the pointer
//   add_i     in   amount to advance by (zero-extended to ptr width)
//   load_v_i  in   load load_i instead of advancing
//   load_i    in   value to load
//   ptr_o     out  current pointer value
// ---------------------------------------------------------------------------
module bp_be_issue_queue_ptr #(
    parameter int ptr_width_p = 4,
    parameter int add_width_p = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [add_width_p-1:0] add_i,
    input  logic                   load_v_i,
    input  logic [ptr_width_p-1:0] load_i,
    output logic [ptr_width_p-1:0] ptr_o
);

    logic [ptr_width_p-1:0] add_ext;

    always_comb begin
        add_ext                   = '0;
        add_ext[add_width_p-1:0]  = add_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_o <= '0;
        end else if (load_v_i) begin
            ptr_o <= load_i;
        end else begin
            ptr_o <= ptr_o + add_ext;
        end
    end

endmodule

// File: rtl/bp_be_issue_queue.sv
// ---------------------------------------------------------------------------
// bp_be_issue_queue
//   Speculative issue queue between the FE queue output and the backend
//   scheduler. Three wrap-bit pointers are kept:
//     wptr - next slot to write
//     rptr - next entry to issue (speculative)
//     cptr - oldest entry not yet committed
//   Entries stay resident from enqueue until commit, so a roll can rewind
//   rptr back to the committed point and re-issue them.
//
//   Optional feature (macro BP_BE_ISSUE_QUEUE_BYPASS_EN): when the queue has
//   no unissued entry, an incoming packet is presented on iss_* in the same
//   cycle. Without the macro there is no combinational enq_* -> iss_* path.
//
// Ports:
//   clk_i        in   clock
//   reset_i      in   synchronous active-high reset
//   enq_data_i   in   incoming packet
//   enq_v_i      in   enqueue valid
//   enq_ready_o  out  space available (registered state only)
//   iss_data_o   out  packet at rptr (don't-care while iss_v_o=0)
//   iss_v_o      out  an unissued entry exists
//   iss_yumi_i   in   consumer takes the issue entry
//   cmt_cnt_i    in   oldest issued entries committed this cycle
//   roll_i       in   rewind rptr to the committed pointer
//   clr_i        in   drop all uncommitted entries
//   occupancy_o  out  wptr - cptr
//   inflight_o   out  rptr - cptr
//   empty_o      out  occupancy == 0
// ---------------------------------------------------------------------------
module bp_be_issue_queue
    import bp_be_pkg::*;
#(
    parameter  int els_p            = 8,
    parameter  int width_p          = 64,
    parameter  int cmt_width_p      = 2,
    localparam int ptr_width_lp     = $clog2(els_p) + 1,
    localparam int cnt_width_lp     = $clog2(els_p + 1),
    localparam int cmt_cnt_width_lp = $clog2(cmt_width_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [width_p-1:0]          enq_data_i,
    input  logic                        enq_v_i,
    output logic                        enq_ready_o,
    output logic [width_p-1:0]          iss_data_o,
    output logic                        iss_v_o,
    input  logic                        iss_yumi_i,
    input  logic [cmt_cnt_width_lp-1:0] cmt_cnt_i,
    input  logic                        roll_i,
    input  logic                        clr_i,
    output logic [cnt_width_lp-1:0]     occupancy_o,
    output logic [cnt_width_lp-1:0]     inflight_o,
    output logic                        empty_o
);

    localparam int idx_width_lp = ptr_width_lp - 1;

    logic [ptr_width_lp-1:0] wptr, rptr, cptr;
    logic [ptr_width_lp-1:0] cptr_next;
    logic [ptr_width_lp-1:0] cmt_ext;
    logic [idx_width_lp-1:0] widx, ridx;
    logic                    full;
    logic                    ptr_eq;
    logic                    enq_fire;
    logic                    iss_fire;
    logic                    rewind_r;

    logic [width_p-1:0] mem [els_p];

    assign widx = wptr[idx_width_lp-1:0];
    assign ridx = rptr[idx_width_lp-1:0];

    // Occupancy/inflight and the full flag come only from registered
    // pointers, so committed entries free space one cycle later.
    assign occupancy_o = cnt_width_lp'(ptr_dist(32'(wptr), 32'(cptr), ptr_width_lp));
    assign inflight_o  = cnt_width_lp'(ptr_dist(32'(rptr), 32'(cptr), ptr_width_lp));
    assign full        = (occupancy_o == cnt_width_lp'(els_p));
    assign empty_o     = (occupancy_o == '0);
    assign enq_ready_o = ~full;
    assign ptr_eq      = (rptr == wptr);

    // Commit is applied every cycle; clr/roll reload from the post-commit
    // value so entries committed this cycle are never re-issued.
    always_comb begin
        cmt_ext                        = '0;
        cmt_ext[cmt_cnt_width_lp-1:0]  = cmt_cnt_i;
    end
    assign cptr_next = cptr + cmt_ext;

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
    logic bypass_v;

    // Nothing unissued is resident: forward the incoming packet directly.
    // It is still written and wptr still advances, so a later roll can
    // re-present it.
    assign bypass_v   = ptr_eq & enq_v_i & enq_ready_o & ~clr_i;
    assign iss_v_o    = ~ptr_eq | bypass_v;
    assign iss_data_o = bypass_v ? enq_data_i : mem[ridx];
`else
    assign iss_v_o    = ~ptr_eq;
    assign iss_data_o = mem[ridx];
`endif

    // clr drops the same-cycle enqueue; roll lets it proceed.
    assign enq_fire = enq_v_i & enq_ready_o & ~clr_i;
    // clr and roll both overwrite rptr, so a same-cycle yumi has no effect.
    assign iss_fire = iss_yumi_i & iss_v_o & ~clr_i & ~roll_i;
    assign rewind_r = clr_i | roll_i;

    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem[widx] <= enq_data_i;
        end
    end

    bp_be_issue_queue_ptr #(
        .ptr_width_p (ptr_width_lp),
        .add_width_p (1)
    ) wptr_reg (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .add_i    (enq_fire),
        .load_v_i (clr_i),
        .load_i   (cptr_next),
        .ptr_o    (wptr)
    );

    bp_be_issue_queue_ptr #(
        .ptr_width_p (ptr_width_lp),
        .add_width_p (1)
    ) rptr_reg (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .add_i    (iss_fire),
        .load_v_i (rewind_r),
        .load_i   (cptr_next),
        .ptr_o    (rptr)
    );

    bp_be_issue_queue_ptr #(
        .ptr_width_p (ptr_width_lp),
        .add_width_p (cmt_cnt_width_lp)
    ) cptr_reg (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .add_i    (cmt_cnt_i),
        .load_v_i (1'b0),
        .load_i   ('0),
        .ptr_o    (cptr)
    );

    yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) iss_yumi_i |-> iss_v_o
    );

    commit_within_inflight: assert property (
        @(posedge clk_i) disable iff (reset_i)
        cnt_width_lp'(cmt_cnt_i) <= inflight_o
    );

endmodule

// File: tb/tb_bp_be_issue_queue.sv
module tb_bp_be_issue_queue;

    localparam int els_lp   = 8;
    localparam int width_lp = 64;
    localparam int cmt_lp   = 2;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic [width_lp-1:0] enq_data_i;
    logic                enq_v_i;
    logic                enq_ready_o;
    logic [width_lp-1:0] iss_data_o;
    logic                iss_v_o;
    logic                iss_yumi_i;
    logic [1:0]          cmt_cnt_i;
    logic                roll_i;
    logic                clr_i;
    logic [3:0]          occupancy_o;
    logic [3:0]          inflight_o;
    logic                empty_o;

    int tests_run    = 0;
    int tests_failed = 0;

    bp_be_issue_queue #(
        .els_p       (els_lp),
        .width_p     (width_lp),
        .cmt_width_p (cmt_lp)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .enq_data_i  (enq_data_i),
        .enq_v_i     (enq_v_i),
        .enq_ready_o (enq_ready_o),
        .iss_data_o  (iss_data_o),
        .iss_v_o     (iss_v_o),
        .iss_yumi_i  (iss_yumi_i),
        .cmt_cnt_i   (cmt_cnt_i),
        .roll_i      (roll_i),
        .clr_i       (clr_i),
        .occupancy_o (occupancy_o),
        .inflight_o  (inflight_o),
        .empty_o     (empty_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        enq_v_i    = 1'b0;
        enq_data_i = '0;
        iss_yumi_i = 1'b0;
        cmt_cnt_i  = 2'd0;
        roll_i     = 1'b0;
        clr_i      = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (iss_v_o !== 1'b0) begin tests_failed++; $display("FAIL reset_iss_v got %0b need 0", iss_v_o); end
        tests_run++; if (enq_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_enq_ready got %0b need 1", enq_ready_o); end
        tests_run++; if (occupancy_o !== 4'd0) begin tests_failed++; $display("FAIL reset_occupancy got %0d need 0", occupancy_o); end
        tests_run++; if (inflight_o !== 4'd0) begin tests_failed++; $display("FAIL reset_inflight got %0d need 0", inflight_o); end
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %0b need 1", empty_o); end
        // Reset in the middle of operation discards contents.
        for (int i = 0; i < 3; i++) begin
            enq_v_i = 1'b1; enq_data_i = 64'h50 + 64'(i);
            tick();
        end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        idle();
        #1;
        tests_run++; if (occupancy_o !== 4'd0) begin tests_failed++; $display("FAIL midreset_occupancy got %0d need 0", occupancy_o); end
        tests_run++; if (iss_v_o !== 1'b0) begin tests_failed++; $display("FAIL midreset_iss_v got %0b need 0", iss_v_o); end
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL midreset_empty got %0b need 1", empty_o); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            enq_v_i = 1'b1; enq_data_i = 64'h10 + 64'(i);
            #1;
            tests_run++; if (enq_ready_o !== 1'b1) begin tests_failed++; $display("FAIL fill_ready_%0d got %0b need 1", i, enq_ready_o); end
            tick();
        end
        idle();
        #1;
        tests_run++; if (enq_ready_o !== 1'b0) begin tests_failed++; $display("FAIL full_enq_ready got %0b need 0", enq_ready_o); end
        tests_run++; if (occupancy_o !== 4'd8) begin tests_failed++; $display("FAIL full_occupancy got %0d need 8", occupancy_o); end
        tests_run++; if (inflight_o !== 4'd0) begin tests_failed++; $display("FAIL full_inflight got %0d need 0", inflight_o); end
        tests_run++; if (iss_v_o !== 1'b1) begin tests_failed++; $display("FAIL full_iss_v got %0b need 1", iss_v_o); end
        for (int i = 0; i < 8; i++) begin
            iss_yumi_i = 1'b1;
            #1;
            tests_run++; if (iss_data_o !== 64'h10 + 64'(i)) begin tests_failed++; $display("FAIL fill_issue_%0d got %0h need %0h", i, iss_data_o, 64'h10 + 64'(i)); end
            tick();
        end
        idle();
        #1;
        tests_run++; if (inflight_o !== 4'd8) begin tests_failed++; $display("FAIL issued_inflight got %0d need 8", inflight_o); end
        tests_run++; if (iss_v_o !== 1'b0) begin tests_failed++; $display("FAIL issued_iss_v got %0b need 0", iss_v_o); end
        tests_run++; if (occupancy_o !== 4'd8) begin tests_failed++; $display("FAIL issued_occupancy got %0d need 8", occupancy_o); end
    endtask

    // Continues from the full, fully-issued state left by test_fill.
    task automatic test_commit();
        for (int i = 0; i < 4; i++) begin
            cmt_cnt_i = 2'd2;
            #1;
            if (i == 0) begin
                tests_run++; if (enq_ready_o !== 1'b0) begin tests_failed++; $display("FAIL commit_same_cycle_ready got %0b need 0", enq_ready_o); end
            end
            tick();
            idle();
            #1;
            tests_run++; if (occupancy_o !== 4'(6 - 2 * i)) begin tests_failed++; $display("FAIL commit_occupancy_%0d got %0d need %0d", i, occupancy_o, 6 - 2 * i); end
            if (i == 0) begin
                tests_run++; if (enq_ready_o !== 1'b1) begin tests_failed++; $display("FAIL commit_next_ready got %0b need 1", enq_ready_o); end
            end
        end
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL commit_empty got %0b need 1", empty_o); end
        tests_run++; if (inflight_o !== 4'd0) begin tests_failed++; $display("FAIL commit_inflight got %0d need 0", inflight_o); end
    endtask

    task automatic test_roll();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            enq_v_i = 1'b1; enq_data_i = 64'h20 + 64'(i);
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            iss_yumi_i = 1'b1;
            #1;
            tests_run++; if (iss_data_o !== 64'h20 + 64'(i)) begin tests_failed++; $display("FAIL roll_issue_%0d got %0h need %0h", i, iss_data_o, 64'h20 + 64'(i)); end
            tick();
        end
        idle();
        cmt_cnt_i = 2'd1;
        tick();
        idle();
        roll_i = 1'b1;
        tick();
        idle();
        #1;
        tests_run++; if (iss_v_o !== 1'b1) begin tests_failed++; $display("FAIL roll_iss_v got %0b need 1", iss_v_o); end
        tests_run++; if (iss_data_o !== 64'h21) begin tests_failed++; $display("FAIL roll_iss_data got %0h need 21", iss_data_o); end
        tests_run++; if (inflight_o !== 4'd0) begin tests_failed++; $display("FAIL roll_inflight got %0d need 0", inflight_o); end
        tests_run++; if (occupancy_o !== 4'd4) begin tests_failed++; $display("FAIL roll_occupancy got %0d need 4", occupancy_o); end
        // Issue one, then roll with a same-cycle yumi (ignored) and enqueue (kept).
        iss_yumi_i = 1'b1;
        tick();
        idle();
        roll_i = 1'b1; iss_yumi_i = 1'b1; enq_v_i = 1'b1; enq_data_i = 64'h25;
        tick();
        idle();
        #1;
        tests_run++; if (iss_data_o !== 64'h21) begin tests_failed++; $display("FAIL roll_yumi_data got %0h need 21", iss_data_o); end
        tests_run++; if (occupancy_o !== 4'd5) begin tests_failed++; $display("FAIL roll_enq_occupancy got %0d need 5", occupancy_o); end
        tests_run++; if (inflight_o !== 4'd0) begin tests_failed++; $display("FAIL roll_yumi_inflight got %0d need 0", inflight_o); end
    endtask

    task automatic test_clr();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            enq_v_i = 1'b1; enq_data_i = 64'h30 + 64'(i);
            tick();
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            iss_yumi_i = 1'b1;
            #1;
            tests_run++; if (iss_data_o !== 64'h30 + 64'(i)) begin tests_failed++; $display("FAIL clr_issue_%0d got %0h need %0h", i, iss_data_o, 64'h30 + 64'(i)); end
            tick();
        end
        idle();
        clr_i = 1'b1; cmt_cnt_i = 2'd1; enq_v_i = 1'b1; enq_data_i = 64'h34;
        tick();
        idle();
        #1;
        tests_run++; if (occupancy_o !== 4'd0) begin tests_failed++; $display("FAIL clr_occupancy got %0d need 0", occupancy_o); end
        tests_run++; if (iss_v_o !== 1'b0) begin tests_failed++; $display("FAIL clr_iss_v got %0b need 0", iss_v_o); end
        tests_run++; if (inflight_o !== 4'd0) begin tests_failed++; $display("FAIL clr_inflight got %0d need 0", inflight_o); end
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL clr_empty got %0b need 1", empty_o); end
        enq_v_i = 1'b1; enq_data_i = 64'h35;
        tick();
        idle();
        #1;
        tests_run++; if (iss_v_o !== 1'b1) begin tests_failed++; $display("FAIL clr_next_iss_v got %0b need 1", iss_v_o); end
        tests_run++; if (iss_data_o !== 64'h35) begin tests_failed++; $display("FAIL clr_next_data got %0h need 35", iss_data_o); end
        tests_run++; if (occupancy_o !== 4'd1) begin tests_failed++; $display("FAIL clr_next_occupancy got %0d need 1", occupancy_o); end
    endtask

    task automatic test_wrap();
        logic [width_lp-1:0] hist [256];
        int mw, mr, mc;
        int k;
        bit fire, yumi;
        do_reset();
        mw = 0; mr = 0; mc = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            idle();
            #1;
            tests_run++; if (occupancy_o !== 4'(mw - mc)) begin tests_failed++; $display("FAIL wrap_occupancy_c%0d got %0d need %0d", cyc, occupancy_o, mw - mc); end
            tests_run++; if (inflight_o !== 4'(mr - mc)) begin tests_failed++; $display("FAIL wrap_inflight_c%0d got %0d need %0d", cyc, inflight_o, mr - mc); end
            tests_run++; if (enq_ready_o !== ((mw - mc) != els_lp)) begin tests_failed++; $display("FAIL wrap_full_c%0d got ready %0b need %0b", cyc, enq_ready_o, (mw - mc) != els_lp); end
            tests_run++; if (empty_o !== (mw == mc)) begin tests_failed++; $display("FAIL wrap_empty_c%0d got %0b need %0b", cyc, empty_o, mw == mc); end
            tests_run++; if (iss_v_o !== (mw != mr)) begin tests_failed++; $display("FAIL wrap_iss_v_c%0d got %0b need %0b", cyc, iss_v_o, mw != mr); end
            if (mw != mr) begin
                tests_run++; if (iss_data_o !== hist[mr]) begin tests_failed++; $display("FAIL wrap_order_c%0d got %0h need %0h", cyc, iss_data_o, hist[mr]); end
            end
            enq_v_i    = ($urandom_range(3) != 0);
            enq_data_i = 64'h40 + 64'(mw);
            fire       = enq_v_i && ((mw - mc) < els_lp);
            if (fire) hist[mw] = enq_data_i;
            yumi       = (mw != mr) && ($urandom_range(1) == 1);
            iss_yumi_i = yumi;
            k          = $urandom_range(2);
            if (k > mr - mc) k = mr - mc;
            cmt_cnt_i  = 2'(k);
            tick();
            if (fire) mw++;
            if (yumi) mr++;
            mc += k;
        end
        idle();
    endtask

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        enq_v_i = 1'b1; enq_data_i = 64'hAA; iss_yumi_i = 1'b1;
        #1;
        tests_run++; if (iss_v_o !== 1'b1) begin tests_failed++; $display("FAIL bypass_iss_v got %0b need 1", iss_v_o); end
        tests_run++; if (iss_data_o !== 64'hAA) begin tests_failed++; $display("FAIL bypass_data got %0h need aa", iss_data_o); end
        tick();
        idle();
        roll_i = 1'b1;
        tick();
        idle();
        #1;
        tests_run++; if (iss_v_o !== 1'b1) begin tests_failed++; $display("FAIL bypass_roll_iss_v got %0b need 1", iss_v_o); end
        tests_run++; if (iss_data_o !== 64'hAA) begin tests_failed++; $display("FAIL bypass_roll_data got %0h need aa", iss_data_o); end
    endtask
`else
    task automatic test_no_bypass();
        do_reset();
        enq_v_i = 1'b1; enq_data_i = 64'hAA;
        #1;
        tests_run++; if (iss_v_o !== 1'b0) begin tests_failed++; $display("FAIL nobypass_same_cycle_iss_v got %0b need 0", iss_v_o); end
        tick();
        idle();
        #1;
        tests_run++; if (iss_v_o !== 1'b1) begin tests_failed++; $display("FAIL nobypass_next_iss_v got %0b need 1", iss_v_o); end
        tests_run++; if (iss_data_o !== 64'hAA) begin tests_failed++; $display("FAIL nobypass_next_data got %0h need aa", iss_data_o); end
    endtask
`endif

    initial begin
        reset_i = 1'b1;
        idle();
        test_reset();
        test_fill();
        test_commit();
        test_roll();
        test_clr();
        test_wrap();
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
        test_bypass();
`else
        test_no_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
